// File: rtl/wave_sdram_arbiter_if.sv
// Signal bundle between the wave download/playback clients, the arbiter and the SDRAM controller.
// The arbiter takes the slave view; the surrounding clients and memory model take the master view.
interface wave_sdram_arbiter_if;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;

  logic        ch0_rd;
  logic [19:0] ch0_addr;
  logic [15:0] ch0_data;
  logic        ch0_valid;
  logic        ch1_rd;
  logic [19:0] ch1_addr;
  logic [15:0] ch1_data;
  logic        ch1_valid;

  logic [24:0] mem_addr;
  logic        mem_rd;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [15:0] mem_dout;
  logic        mem_ack;

  logic        overrun;
  logic        timeout_err;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  ch0_rd, ch0_addr, ch1_rd, ch1_addr,
    input  mem_dout, mem_ack,
    output dl_wait, ch0_data, ch0_valid, ch1_data, ch1_valid,
    output mem_addr, mem_rd, mem_we, mem_din,
    output overrun, timeout_err
  );

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output ch0_rd, ch0_addr, ch1_rd, ch1_addr,
    output mem_dout, mem_ack,
    input  dl_wait, ch0_data, ch0_valid, ch1_data, ch1_valid,
    input  mem_addr, mem_rd, mem_we, mem_din,
    input  overrun, timeout_err
  );
endinterface

// File: rtl/wave_sdram_arbiter.sv
// Shares one SDRAM command port between the wave-ROM download writer and two sample-read channels.
// Download has absolute priority, reads are round-robin, one command in flight with an ack watchdog.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | pick a pending source (dl first, then round-robin channels)
//   S_ISSUE | command pulse on mem_rd/mem_we is visible this cycle
//   S_WAIT  | waiting for mem_ack, watchdog counting down to abort
module wave_sdram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  wave_sdram_arbiter_if.slave   io_bus
);

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_DL  = 2'd0,
    G_CH0 = 2'd1,
    G_CH1 = 2'd2
  } gnt_t;

  state_t      r_state;
  state_t      w_state_nxt;
  gnt_t        r_gnt;
  gnt_t        w_gnt_nxt;

  logic        w_gnt_dl;
  logic        w_gnt_ch0;
  logic        w_gnt_ch1;
  logic        w_ack_done;
  logic        w_abort;
  logic        w_xfer_end;

  logic        w_dl_busy;
  logic        w_dl_stb;
  logic        w_ch0_stb;
  logic        w_ch1_stb;

  logic        r_dl_pend;
  logic        r_ch0_pend;
  logic        r_ch1_pend;
  logic        r_rr_ptr;
  logic [24:0] r_dl_addr;
  logic [7:0]  r_dl_data;
  logic [19:0] r_ch0_addr;
  logic [19:0] r_ch1_addr;
  logic [7:0]  r_wdog;

  logic        r_mem_rd;
  logic        r_mem_we;
  logic [24:0] r_mem_addr;
  logic [7:0]  r_mem_din;
  logic        r_dl_wait;
  logic        r_ch0_valid;
  logic        r_ch1_valid;
  logic [15:0] r_ch0_data;
  logic [15:0] r_ch1_data;
  logic        r_overrun;
  logic        r_timeout_err;

  // dl_wait covers the whole life of a download write, so a second dl_wr is refused until it retires
  assign w_dl_busy  = r_dl_pend | r_dl_wait;
  assign w_dl_stb   = io_bus.dl_wr & ~w_dl_busy;
  assign w_ch0_stb  = io_bus.ch0_rd & ~io_bus.dl_active;
  assign w_ch1_stb  = io_bus.ch1_rd & ~io_bus.dl_active;
  assign w_xfer_end = w_ack_done | w_abort;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= G_DL;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gnt_dl    = 1'b0;
    w_gnt_ch0   = 1'b0;
    w_gnt_ch1   = 1'b0;
    w_ack_done  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_dl_pend) begin
          w_gnt_dl    = 1'b1;
          w_gnt_nxt   = G_DL;
          w_state_nxt = S_ISSUE;
        end else if (r_ch0_pend && (!r_ch1_pend || !r_rr_ptr)) begin
          w_gnt_ch0   = 1'b1;
          w_gnt_nxt   = G_CH0;
          w_state_nxt = S_ISSUE;
        end else if (r_ch1_pend) begin
          w_gnt_ch1   = 1'b1;
          w_gnt_nxt   = G_CH1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.mem_ack) begin
          w_ack_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == 8'd0) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture; a fresh strobe wins over the grant that clears the same source on this edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_pend  <= 1'b0;
      r_dl_addr  <= '0;
      r_dl_data  <= '0;
      r_ch0_pend <= 1'b0;
      r_ch0_addr <= '0;
      r_ch1_pend <= 1'b0;
      r_ch1_addr <= '0;
      r_rr_ptr   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_dl_stb) begin
        r_dl_pend <= 1'b1;
        r_dl_addr <= io_bus.dl_addr;
        r_dl_data <= io_bus.dl_data;
      end else if (w_gnt_dl) begin
        r_dl_pend <= 1'b0;
      end

      if (io_bus.dl_active) begin
        r_ch0_pend <= 1'b0;
      end else if (w_ch0_stb) begin
        r_ch0_pend <= 1'b1;
        r_ch0_addr <= io_bus.ch0_addr;
      end else if (w_gnt_ch0) begin
        r_ch0_pend <= 1'b0;
      end

      if (io_bus.dl_active) begin
        r_ch1_pend <= 1'b0;
      end else if (w_ch1_stb) begin
        r_ch1_pend <= 1'b1;
        r_ch1_addr <= io_bus.ch1_addr;
      end else if (w_gnt_ch1) begin
        r_ch1_pend <= 1'b0;
      end

      if (w_gnt_ch0) begin
        r_rr_ptr <= 1'b1;
      end else if (w_gnt_ch1) begin
        r_rr_ptr <= 1'b0;
      end

      if ((io_bus.dl_wr & w_dl_busy) | (w_ch0_stb & r_ch0_pend) | (w_ch1_stb & r_ch1_pend)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Command issue, watchdog and read-data return
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_rd      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_wdog        <= '0;
      r_dl_wait     <= 1'b0;
      r_ch0_valid   <= 1'b0;
      r_ch1_valid   <= 1'b0;
      r_ch0_data    <= '0;
      r_ch1_data    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mem_rd    <= w_gnt_ch0 | w_gnt_ch1;
      r_mem_we    <= w_gnt_dl;
      r_ch0_valid <= w_ack_done & (r_gnt == G_CH0);
      r_ch1_valid <= w_ack_done & (r_gnt == G_CH1);

      if (w_gnt_dl) begin
        r_mem_addr <= r_dl_addr;
        r_mem_din  <= r_dl_data;
      end else if (w_gnt_ch0) begin
        r_mem_addr <= {4'b0, r_ch0_addr, 1'b0};
      end else if (w_gnt_ch1) begin
        r_mem_addr <= {4'b0, r_ch1_addr, 1'b0};
      end

      if (r_state == S_ISSUE) begin
        r_wdog <= C_TIMEOUT;
      end else if ((r_state == S_WAIT) && (r_wdog != 8'd0)) begin
        r_wdog <= r_wdog - 8'd1;
      end

      if (w_dl_stb) begin
        r_dl_wait <= 1'b1;
      end else if (w_xfer_end && (r_gnt == G_DL)) begin
        r_dl_wait <= 1'b0;
      end

      if (w_ack_done && (r_gnt == G_CH0)) begin
        r_ch0_data <= io_bus.mem_dout;
      end
      if (w_ack_done && (r_gnt == G_CH1)) begin
        r_ch1_data <= io_bus.mem_dout;
      end

      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign io_bus.mem_rd      = r_mem_rd;
  assign io_bus.mem_we      = r_mem_we;
  assign io_bus.mem_addr    = r_mem_addr;
  assign io_bus.mem_din     = r_mem_din;
  assign io_bus.dl_wait     = r_dl_wait;
  assign io_bus.ch0_valid   = r_ch0_valid;
  assign io_bus.ch1_valid   = r_ch1_valid;
  assign io_bus.ch0_data    = r_ch0_data;
  assign io_bus.ch1_data    = r_ch1_data;
  assign io_bus.overrun     = r_overrun;
  assign io_bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_wave_sdram_arbiter.sv
// Directed bench for wave_sdram_arbiter: a per-cycle vector table followed by hand-written
// sequences for round-robin, overrun, watchdog abort and mid-transaction reset.
module tb_wave_sdram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wave_sdram_arbiter_if u_if ();

  wave_sdram_arbiter #(.TIMEOUT(8)) u_dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .io_bus  (u_if)
  );

  typedef struct {
    logic        dl_act;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        c0_rd;
    logic [19:0] c0_addr;
    logic        c1_rd;
    logic [19:0] c1_addr;
    logic        ack;
    logic [15:0] dout;
    logic        e_rd;
    logic        e_we;
    logic [24:0] e_addr;
    logic [7:0]  e_din;
    logic        e_dlw;
    logic        e_v0;
    logic        e_v1;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
    logic        e_ovr;
    logic        e_tmo;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  // Push the working record, then clear the one-cycle inputs and pulse expectations.
  task automatic push();
    tbl.push_back(v);
    v.dl_wr = 1'b0;
    v.c0_rd = 1'b0;
    v.c1_rd = 1'b0;
    v.ack   = 1'b0;
    v.dout  = '0;
    v.e_rd  = 1'b0;
    v.e_we  = 1'b0;
    v.e_v0  = 1'b0;
    v.e_v1  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_rd(input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (u_if.mem_rd) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic ack_now(input logic [15:0] d);
    u_if.mem_ack  = 1'b1;
    u_if.mem_dout = d;
    @(negedge clk);
    u_if.mem_ack  = 1'b0;
    u_if.mem_dout = '0;
  endtask

  task automatic rd_req(input int ch, input logic [19:0] a);
    if (ch == 0) begin
      u_if.ch0_rd = 1'b1; u_if.ch0_addr = a;
    end else begin
      u_if.ch1_rd = 1'b1; u_if.ch1_addr = a;
    end
    @(negedge clk);
    u_if.ch0_rd = 1'b0;
    u_if.ch1_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [71:0] got, req;
    logic [24:0] rr_addr [4];
    logic [1:0]  rr_vld  [4];
    int          c, extra, tcyc, seen_v;

    u_if.dl_active = 1'b0; u_if.dl_wr = 1'b0; u_if.dl_addr = '0; u_if.dl_data = '0;
    u_if.ch0_rd = 1'b0; u_if.ch0_addr = '0; u_if.ch1_rd = 1'b0; u_if.ch1_addr = '0;
    u_if.mem_ack = 1'b0; u_if.mem_dout = '0;
    rst_n = 1'b0;

    // ---------------- vector table ----------------
    v = '{default: '0};
    push();                                                         // k0 reset state
    v.c1_rd = 1; v.c1_addr = 20'hABCDE; push();                     // k1 strobe
    push();                                                         // k2 pending, grant
    v.e_rd = 1; v.e_addr = 25'h01579BC; push();                     // k3 mem_rd
    push(); push(); push();                                         // k4..k6 wait
    v.ack = 1; v.dout = 16'h1234; push();                           // k7 ack
    v.e_v1 = 1; v.e_d1 = 16'h1234; v.ack = 1; v.dout = 16'hDEAD; push(); // k8 valid, stray ack in IDLE
    push();                                                         // k9 stray ack ignored
    v.c1_rd = 1; v.c1_addr = 20'h00003; push();                     // k10 keep FSM busy
    v.c0_rd = 1; v.c0_addr = 20'h00005; push();                     // k11 ch0 pending behind ch1
    v.e_rd = 1; v.e_addr = 25'h0000006;
    v.dl_act = 1; v.dl_wr = 1; v.dl_addr = 25'h0000100; v.dl_data = 8'h5A; push(); // k12
    v.e_dlw = 1; push();                                            // k13
    v.ack = 1; v.dout = 16'h0BEE; push();                           // k14 ack ch1
    v.e_v1 = 1; v.e_d1 = 16'h0BEE; push();                          // k15 dl granted
    v.e_we = 1; v.e_addr = 25'h0000100; v.e_din = 8'h5A; push();    // k16 mem_we
    push();                                                         // k17
    v.ack = 1; v.dout = 16'hFFFF; push();                           // k18 ack dl
    v.e_dlw = 0; v.dl_act = 0; push();                              // k19 dl_wait dropped
    push(); push();                                                 // k20,k21 ch0 was flushed

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      got = {u_if.mem_rd, u_if.mem_we, u_if.mem_addr, u_if.mem_din, u_if.dl_wait,
             u_if.ch0_valid, u_if.ch1_valid, u_if.ch0_data, u_if.ch1_data,
             u_if.overrun, u_if.timeout_err};
      req = {tbl[i].e_rd, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_din, tbl[i].e_dlw,
             tbl[i].e_v0, tbl[i].e_v1, tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_ovr, tbl[i].e_tmo};
      n_vec++;
      if (got !== req) begin
        n_err++;
        $display("FAIL vec%0d: got rd/we=%b%b addr=%h din=%h dlw=%b v=%b%b d0=%h d1=%h ovr=%b tmo=%b, required rd/we=%b%b addr=%h din=%h dlw=%b v=%b%b d0=%h d1=%h ovr=%b tmo=%b",
                 i, got[71], got[70], got[69:45], got[44:37], got[36], got[35], got[34],
                 got[33:18], got[17:2], got[1], got[0],
                 req[71], req[70], req[69:45], req[44:37], req[36], req[35], req[34],
                 req[33:18], req[17:2], req[1], req[0]);
      end
      u_if.dl_active = tbl[i].dl_act; u_if.dl_wr = tbl[i].dl_wr;
      u_if.dl_addr = tbl[i].dl_addr;  u_if.dl_data = tbl[i].dl_data;
      u_if.ch0_rd = tbl[i].c0_rd;     u_if.ch0_addr = tbl[i].c0_addr;
      u_if.ch1_rd = tbl[i].c1_rd;     u_if.ch1_addr = tbl[i].c1_addr;
      u_if.mem_ack = tbl[i].ack;      u_if.mem_dout = tbl[i].dout;
    end
    @(negedge clk);
    u_if.dl_active = 1'b0; u_if.dl_wr = 1'b0; u_if.ch0_rd = 1'b0; u_if.ch1_rd = 1'b0;
    u_if.mem_ack = 1'b0; u_if.mem_dout = '0;

    // ---------------- round-robin: two simultaneous pairs ----------------
    rr_addr[0] = 25'h0001400; rr_vld[0] = 2'b01;
    rr_addr[1] = 25'h0001600; rr_vld[1] = 2'b10;
    rr_addr[2] = 25'h0001800; rr_vld[2] = 2'b01;
    rr_addr[3] = 25'h0001A00; rr_vld[3] = 2'b10;
    for (int g = 0; g < 4; g++) begin
      if (g == 0 || g == 2) begin
        u_if.ch0_rd = 1'b1; u_if.ch0_addr = (g == 0) ? 20'h00A00 : 20'h00C00;
        u_if.ch1_rd = 1'b1; u_if.ch1_addr = (g == 0) ? 20'h00B00 : 20'h00D00;
        @(negedge clk);
        u_if.ch0_rd = 1'b0; u_if.ch1_rd = 1'b0;
      end
      wait_rd(20, c);
      chk($sformatf("rr_rd_seen%0d", g), 32'(c > 0), 32'd1);
      chk($sformatf("rr_addr%0d", g), 32'(u_if.mem_addr), 32'(rr_addr[g]));
      @(negedge clk);
      ack_now(16'h1000 + 16'(g));
      chk($sformatf("rr_valid%0d", g), 32'({u_if.ch1_valid, u_if.ch0_valid}), 32'(rr_vld[g]));
      chk($sformatf("rr_data%0d", g),
          32'(rr_vld[g][0] ? u_if.ch0_data : u_if.ch1_data), 32'(16'h1000 + 16'(g)));
    end
    chk("rr_no_overrun", 32'(u_if.overrun), 32'd0);

    // ---------------- overrun: ch0 strobed twice while ch1 is in flight ----------------
    rd_req(1, 20'h00020);
    wait_rd(20, c);
    chk("ovr_ch1_addr", 32'(u_if.mem_addr), 32'h0000040);
    @(negedge clk);
    u_if.ch0_rd = 1'b1; u_if.ch0_addr = 20'h00001;
    @(negedge clk);
    u_if.ch0_rd = 1'b1; u_if.ch0_addr = 20'h00002;
    chk("ovr_before_second", 32'(u_if.overrun), 32'd0);
    @(negedge clk);
    u_if.ch0_rd = 1'b0;
    chk("ovr_after_second", 32'(u_if.overrun), 32'd1);
    ack_now(16'h5555);
    chk("ovr_ch1_data", 32'(u_if.ch1_data), 32'h5555);
    wait_rd(20, c);
    chk("ovr_ch0_seen", 32'(c > 0), 32'd1);
    chk("ovr_ch0_addr", 32'(u_if.mem_addr), 32'h0000004);
    @(negedge clk);
    ack_now(16'h6666);
    chk("ovr_ch0_data", 32'(u_if.ch0_data), 32'h6666);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (u_if.mem_rd) extra++;
    end
    chk("ovr_single_rd", 32'(extra), 32'd0);
    chk("ovr_sticky", 32'(u_if.overrun), 32'd1);

    // ---------------- watchdog: ch0 read never acknowledged ----------------
    rd_req(0, 20'h00077);
    wait_rd(20, c);
    chk("wd_addr", 32'(u_if.mem_addr), 32'h00000EE);
    chk("wd_tmo_before", 32'(u_if.timeout_err), 32'd0);
    tcyc = -1;
    seen_v = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (u_if.ch0_valid) seen_v = 1;
      if (u_if.timeout_err) begin
        tcyc = i;
        break;
      end
    end
    chk("wd_abort_cycle", 32'(tcyc), 32'd10);
    chk("wd_no_valid", 32'(seen_v), 32'd0);
    chk("wd_data_kept", 32'(u_if.ch0_data), 32'h6666);
    rd_req(1, 20'h00099);
    wait_rd(20, c);
    chk("wd_next_addr", 32'(u_if.mem_addr), 32'h0000132);
    @(negedge clk);
    ack_now(16'h7777);
    chk("wd_next_valid", 32'(u_if.ch1_valid), 32'd1);
    chk("wd_next_data", 32'(u_if.ch1_data), 32'h7777);
    chk("wd_tmo_sticky", 32'(u_if.timeout_err), 32'd1);

    // ---------------- reset in the middle of WAIT ----------------
    rd_req(0, 20'h00123);
    wait_rd(20, c);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_flags", 32'({u_if.mem_rd, u_if.mem_we, u_if.dl_wait, u_if.ch0_valid,
                          u_if.ch1_valid, u_if.overrun, u_if.timeout_err}), 32'd0);
    chk("rst_mem_addr", 32'(u_if.mem_addr), 32'd0);
    chk("rst_mem_din", 32'(u_if.mem_din), 32'd0);
    chk("rst_data", 32'({u_if.ch0_data, u_if.ch1_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_now(16'hBAD0);
    chk("rst_stray_ack_valid", 32'({u_if.ch1_valid, u_if.ch0_valid}), 32'd0);
    chk("rst_stray_ack_data", 32'(u_if.ch0_data), 32'd0);
    rd_req(0, 20'h00010);
    chk("rst_rd_t1", 32'(u_if.mem_rd), 32'd0);
    @(negedge clk);
    chk("rst_rd_t2", 32'(u_if.mem_rd), 32'd1);
    chk("rst_rd_addr", 32'(u_if.mem_addr), 32'h0000020);
    @(negedge clk);
    chk("rst_rd_t3", 32'(u_if.mem_rd), 32'd0);
    ack_now(16'h0042);
    chk("rst_rd_valid", 32'(u_if.ch0_valid), 32'd1);
    chk("rst_rd_data", 32'(u_if.ch0_data), 32'h0042);

    // ---------------- download write refused while dl_wait is high ----------------
    u_if.dl_active = 1'b1;
    u_if.dl_wr = 1'b1; u_if.dl_addr = 25'h0000200; u_if.dl_data = 8'h11;
    @(negedge clk);
    u_if.dl_wr = 1'b1; u_if.dl_addr = 25'h0000300; u_if.dl_data = 8'h22;
    chk("dl_wait_set", 32'(u_if.dl_wait), 32'd1);
    chk("dl_ovr_clear", 32'(u_if.overrun), 32'd0);
    @(negedge clk);
    u_if.dl_wr = 1'b0;
    chk("dl_we", 32'(u_if.mem_we), 32'd1);
    chk("dl_addr", 32'(u_if.mem_addr), 32'h0000200);
    chk("dl_din", 32'(u_if.mem_din), 32'h11);
    chk("dl_overrun", 32'(u_if.overrun), 32'd1);
    @(negedge clk);
    chk("dl_wait_hold", 32'(u_if.dl_wait), 32'd1);
    ack_now(16'h0000);
    chk("dl_wait_drop", 32'(u_if.dl_wait), 32'd0);
    u_if.dl_active = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (u_if.mem_we) extra++;
    end
    chk("dl_single_we", 32'(extra), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
